// File: rtl/spi_target_port_if.sv
// Bus bundle for spi_target_port: SPI pins and host-side rx/tx buffer access.
// master = initiator/host side, slave = the target endpoint.
interface spi_target_port_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
);
  logic                  spiClk;
  logic                  cs;
  logic                  mosi;
  logic                  miso;
  logic [ADDR_WIDTH-1:0] tx_addr;
  logic [DATA_WIDTH-1:0] tx_byte;
  logic                  tx_wr;
  logic [ADDR_WIDTH-1:0] rx_addr;
  logic [DATA_WIDTH-1:0] rx_byte;
  logic                  rx_rd;
  logic [ADDR_WIDTH:0]   rx_count;
  logic                  busy;
  logic                  trx_complete;
  logic                  overrun;

  modport master (
    output spiClk, cs, mosi, tx_addr, tx_byte, tx_wr, rx_addr, rx_rd,
    input  miso, rx_byte, rx_count, busy, trx_complete, overrun
  );

  modport slave (
    input  spiClk, cs, mosi, tx_addr, tx_byte, tx_wr, rx_addr, rx_rd,
    output miso, rx_byte, rx_count, busy, trx_complete, overrun
  );
endinterface

// File: rtl/spi_target_port.sv
// SPI mode-0 target oversampled in the sysClk domain, with tx/rx byte buffers.
// Build option SPI_TARGET_ECHO_EN: miso echoes the previous received byte instead of tx_buf.
//
// state  | meaning
// SIdle  | waiting for cs fall, miso low
// SShift | shifting bits on synced spiClk edges
// SByte  | one cycle: store completed byte, reload tx shifter
// SDone  | one cycle: publish rx_count, pulse trx_complete
module spi_target_port #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 4,
  parameter int ADDR_WIDTH = 2
) (
  input logic             sysClk,
  input logic             reset,
  spi_target_port_if.slave bus
);

  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0]       LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(BUF_DEPTH);

  typedef enum logic [1:0] {SIdle, SShift, SByte, SDone} state_t;

  state_t                state_q, state_d;
  logic [2:0]            sclk_q;
  logic [2:0]            cs_q;
  logic [1:0]            mosi_q;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH:0]   byte_idx_q, byte_idx_d, byte_idx_nx;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  overrun_q, overrun_d;
  logic [ADDR_WIDTH:0]   rx_count_q, rx_count_d;
  logic [DATA_WIDTH-1:0] rx_byte_q;
  logic [DATA_WIDTH-1:0] rx_buf_q [BUF_DEPTH];
  logic                  rx_we;
  logic [DATA_WIDTH-1:0] first_tx;
  logic [DATA_WIDTH-1:0] next_tx;
  logic                  busy;
  logic                  sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;

  // [0],[1] synchronizer, [2] history for edge detection
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign mosi_s    = mosi_q[1];

  assign busy        = (state_q == SShift) || (state_q == SByte);
  assign byte_idx_nx = (byte_idx_q < DEPTH_C) ? byte_idx_q + 1'b1 : byte_idx_q;

`ifdef SPI_TARGET_ECHO_EN
  logic unused_tx;
  assign unused_tx = ^{bus.tx_addr, bus.tx_byte, bus.tx_wr};
  assign first_tx  = '0;
  assign next_tx   = rx_shift_q;
`else
  logic [DATA_WIDTH-1:0] tx_buf_q [BUF_DEPTH];

  assign first_tx = tx_buf_q[0];
  assign next_tx  = (byte_idx_nx < DEPTH_C) ? tx_buf_q[byte_idx_nx[ADDR_WIDTH-1:0]] : '0;

  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) tx_buf_q[i] <= '0;
    end else if (!bus.tx_wr && !busy) begin
      tx_buf_q[bus.tx_addr] <= bus.tx_byte;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    overrun_d  = overrun_q;
    rx_count_d = rx_count_q;
    rx_we      = 1'b0;
    unique case (state_q)
      SIdle: begin
        if (cs_fall) begin
          tx_shift_d = first_tx;
          bit_cnt_d  = '0;
          byte_idx_d = '0;
          overrun_d  = 1'b0;
          state_d    = SShift;
        end
      end
      SShift: begin
        if (cs_rise) begin
          state_d = SDone;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = SByte;
        end else if (sclk_fall && (bit_cnt_q != '0)) begin
          tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
        end
      end
      SByte: begin
        // The completed byte is kept even if cs rises in this very cycle
        if (byte_idx_q < DEPTH_C) rx_we = 1'b1;
        else                      overrun_d = 1'b1;
        byte_idx_d = byte_idx_nx;
        tx_shift_d = next_tx;
        bit_cnt_d  = '0;
        state_d    = cs_rise ? SDone : SShift;
      end
      SDone: begin
        rx_count_d = byte_idx_q;
        state_d    = SIdle;
      end
      default: state_d = SIdle;
    endcase
  end

  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      state_q    <= SIdle;
      sclk_q     <= '0;
      cs_q       <= '0;
      mosi_q     <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      overrun_q  <= 1'b0;
      rx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      sclk_q     <= {sclk_q[1:0], bus.spiClk};
      cs_q       <= {cs_q[1:0], bus.cs};
      mosi_q     <= {mosi_q[0], bus.mosi};
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      overrun_q  <= overrun_d;
      rx_count_q <= rx_count_d;
    end
  end

  // A read of the slot being written in SByte returns the old contents
  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) rx_buf_q[i] <= '0;
      rx_byte_q <= '0;
    end else begin
      if (rx_we) rx_buf_q[byte_idx_q[ADDR_WIDTH-1:0]] <= rx_shift_q;
      if (!bus.rx_rd) rx_byte_q <= rx_buf_q[bus.rx_addr];
    end
  end

  assign bus.miso         = busy ? tx_shift_q[DATA_WIDTH-1] : 1'b0;
  assign bus.rx_byte      = rx_byte_q;
  assign bus.rx_count     = rx_count_q;
  assign bus.busy         = busy;
  assign bus.trx_complete = (state_q == SDone);
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_spi_target_port.sv
// Directed-vector bench for spi_target_port: bit-bangs the SPI initiator side
// and checks miso bytes, rx buffer contents and status outputs.
module tb_spi_target_port;

  logic sysClk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   trx_seen = 0;

  always #5 sysClk = ~sysClk;

  spi_target_port_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus ();

  spi_target_port #(.DATA_WIDTH(8), .BUF_DEPTH(4), .ADDR_WIDTH(2)) dut (
    .sysClk(sysClk),
    .reset (reset),
    .bus   (bus)
  );

  always @(negedge sysClk) if (bus.trx_complete === 1'b1) trx_seen++;

  typedef struct {
    int              nbytes;
    logic [0:5][7:0] mosi;
    int              pbits;
    logic [2:0]      pval;
    bit              wr_mid;
    bit              pre_wr;
    logic [0:5][7:0] miso;
    logic [0:3][7:0] rx;
    int              cnt;
    bit              ov;
  } vec_t;

  vec_t vecs [6];

  task automatic cyc(input int n);
    repeat (n) @(posedge sysClk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic host_write(input logic [1:0] a, input logic [7:0] d);
    bus.tx_addr = a;
    bus.tx_byte = d;
    bus.tx_wr   = 1'b0;
    cyc(1);
    bus.tx_wr   = 1'b1;
  endtask

  task automatic read_rx(input logic [1:0] a, output logic [7:0] d);
    bus.rx_addr = a;
    bus.rx_rd   = 1'b0;
    cyc(1);
    bus.rx_rd   = 1'b1;
    d = bus.rx_byte;
  endtask

  // half-period of 8 sysClk; miso sampled as spiClk rises
  task automatic send_bit(input logic b, output logic m);
    bus.mosi = b;
    cyc(8);
    m = bus.miso;
    bus.spiClk = 1'b1;
    cyc(8);
    bus.spiClk = 1'b0;
  endtask

  task automatic spi_xfer(input logic [0:5][7:0] mb, input int nb, input int pb,
                          input logic [2:0] pv, input bit wr_mid,
                          output logic [0:5][7:0] mr);
    logic m;
    mr = '0;
    bus.cs = 1'b0;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 8; i++) begin
        send_bit(mb[b][7-i], m);
        mr[b][7-i] = m;
        if (wr_mid && b == 0 && i == 3) host_write(2'd1, 8'hFF);
      end
    end
    for (int i = 0; i < pb; i++) send_bit(pv[pb-1-i], m);
    cyc(8);
    bus.cs = 1'b1;
    cyc(8);
  endtask

  function automatic logic [7:0] exp_miso(input vec_t v, input int b);
`ifdef SPI_TARGET_ECHO_EN
    return (b == 0) ? 8'h00 : v.mosi[b-1];
`else
    return v.miso[b];
`endif
  endfunction

  initial begin
    logic [0:5][7:0] got;
    logic [7:0]      rd;
    logic            m;
    int              t0;
    bit              busy_seen;

    reset = 1'b0;
    bus.spiClk = 1'b0; bus.cs = 1'b1; bus.mosi = 1'b0;
    bus.tx_addr = '0; bus.tx_byte = '0; bus.tx_wr = 1'b1;
    bus.rx_addr = '0; bus.rx_rd = 1'b1;
    cyc(3);
    reset = 1'b1;
    cyc(4);
    check("rst_miso", bus.miso, 0);
    check("rst_rx_byte", bus.rx_byte, 0);
    check("rst_rx_count", bus.rx_count, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_trx_seen", trx_seen, 0);
    check("rst_overrun", bus.overrun, 0);

    host_write(2'd0, 8'hA1);
    host_write(2'd1, 8'h2A);
    host_write(2'd2, 8'h32);
    host_write(2'd3, 8'h5C);

    vecs[0] = '{nbytes:3, mosi:{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00}, pbits:0, pval:3'b000,
                wr_mid:0, pre_wr:0, miso:{8'hA1, 8'h2A, 8'h32, 8'h00, 8'h00, 8'h00},
                rx:{8'h11, 8'h22, 8'h33, 8'h00}, cnt:3, ov:0};
    vecs[1] = '{nbytes:6, mosi:{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, pbits:0, pval:3'b000,
                wr_mid:0, pre_wr:0, miso:{8'hA1, 8'h2A, 8'h32, 8'h5C, 8'h00, 8'h00},
                rx:{8'h01, 8'h02, 8'h03, 8'h04}, cnt:4, ov:1};
    vecs[2] = '{nbytes:1, mosi:{8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, pbits:3, pval:3'b101,
                wr_mid:0, pre_wr:0, miso:{8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                rx:{8'h55, 8'h02, 8'h03, 8'h04}, cnt:1, ov:0};
    vecs[3] = '{nbytes:2, mosi:{8'hC3, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00}, pbits:0, pval:3'b000,
                wr_mid:1, pre_wr:0, miso:{8'hA1, 8'h2A, 8'h00, 8'h00, 8'h00, 8'h00},
                rx:{8'hC3, 8'h3C, 8'h03, 8'h04}, cnt:2, ov:0};
    vecs[4] = '{nbytes:2, mosi:{8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00}, pbits:0, pval:3'b000,
                wr_mid:0, pre_wr:1, miso:{8'hA1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00},
                rx:{8'h0F, 8'hF0, 8'h03, 8'h04}, cnt:2, ov:0};
    vecs[5] = '{nbytes:3, mosi:{8'h9A, 8'hBC, 8'hDE, 8'h00, 8'h00, 8'h00}, pbits:0, pval:3'b000,
                wr_mid:0, pre_wr:0, miso:{8'hA1, 8'hFF, 8'h32, 8'h00, 8'h00, 8'h00},
                rx:{8'h9A, 8'hBC, 8'hDE, 8'h04}, cnt:3, ov:0};

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].pre_wr) host_write(2'd1, 8'hFF);
      t0 = trx_seen;
      spi_xfer(vecs[v].mosi, vecs[v].nbytes, vecs[v].pbits, vecs[v].pval, vecs[v].wr_mid, got);
      for (int b = 0; b < vecs[v].nbytes; b++)
        check($sformatf("v%0d_miso%0d", v, b), got[b], exp_miso(vecs[v], b));
      check($sformatf("v%0d_trx_pulses", v), trx_seen - t0, 1);
      check($sformatf("v%0d_rx_count", v), bus.rx_count, vecs[v].cnt);
      check($sformatf("v%0d_overrun", v), bus.overrun, vecs[v].ov);
      check($sformatf("v%0d_busy", v), bus.busy, 0);
      for (int a = 0; a < 4; a++) begin
        read_rx(2'(a), rd);
        check($sformatf("v%0d_rx%0d", v, a), rd, vecs[v].rx[a]);
      end
    end

    // reset mid-transaction: one full byte plus 4 bits, then reset while spiClk high
    bus.cs = 1'b0;
    for (int i = 0; i < 12; i++) send_bit(1'(i % 2), m);
    bus.mosi = 1'b1;
    cyc(8);
    bus.spiClk = 1'b1;
    cyc(3);
    check("pre_rst_busy", bus.busy, 1);
    #2 reset = 1'b0;
    #1;
    check("midrst_miso", bus.miso, 0);
    check("midrst_rx_byte", bus.rx_byte, 0);
    check("midrst_rx_count", bus.rx_count, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_trx", bus.trx_complete, 0);
    check("midrst_overrun", bus.overrun, 0);
    bus.spiClk = 1'b0;
    cyc(3);
    reset = 1'b1;

    busy_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, m);
      if (bus.busy !== 1'b0) busy_seen = 1'b1;
    end
    check("cs_low_after_rst_busy", busy_seen, 0);
    read_rx(2'd0, rd);
    check("cs_low_after_rst_rx0", rd, 0);
    t0 = trx_seen;
    cyc(8);
    bus.cs = 1'b1;
    cyc(10);
    check("cs_rise_idle_no_pulse", trx_seen - t0, 0);
    check("cs_rise_idle_busy", bus.busy, 0);

    host_write(2'd0, 8'hA1);
    t0 = trx_seen;
    spi_xfer({8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 0, 3'b000, 1'b0, got);
`ifdef SPI_TARGET_ECHO_EN
    check("post_rst_miso0", got[0], 8'h00);
`else
    check("post_rst_miso0", got[0], 8'hA1);
`endif
    check("post_rst_trx", trx_seen - t0, 1);
    check("post_rst_rx_count", bus.rx_count, 1);
    read_rx(2'd0, rd);
    check("post_rst_rx0", rd, 8'h77);
    read_rx(2'd1, rd);
    check("post_rst_rx1", rd, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
